// File: rtl/pid_steering_if.sv
// pid_steering_if: error-sample inputs and steering/speed outputs of the line-follow PID
//   error        signed 32  centre-line error, positive = path left of centre
//   error_ready  level      new error sample available (rising edge counts)
//   end_of_line  level      no path found in frame (rising edge counts)
//   steer        signed 16  saturated PID output
//   left_speed   10         left wheel command
//   right_speed  10         right wheel command
//   valid        1          one-cycle pulse when steer/speeds update
//   line_lost    1          lost-line stop active
interface pid_steering_if;
   logic signed [31:0] error;
   logic               error_ready;
   logic               end_of_line;
   logic signed [15:0] steer;
   logic        [9:0]  left_speed;
   logic        [9:0]  right_speed;
   logic               valid;
   logic               line_lost;
   modport master (
      output error, error_ready, end_of_line,
      input  steer, left_speed, right_speed, valid, line_lost
   );
   modport slave (
      input  error, error_ready, end_of_line,
      output steer, left_speed, right_speed, valid, line_lost
   );
endinterface

// File: rtl/pid_steering.sv
// pid_steering: PID steering controller turning a per-frame line error into wheel speeds
//   clk    system clock, all logic on posedge
//   reset  synchronous active-high reset
//   bus    pid_steering_if.slave: error/error_ready/end_of_line in, steer/speeds/valid/line_lost out
module pid_steering #(
   parameter int KP          = 4,
   parameter int KI          = 1,
   parameter int KD          = 2,
   parameter int SHIFT       = 2,
   parameter int ERR_MAX     = 160,
   parameter int I_MAX       = 1000,
   parameter int OUT_MAX     = 200,
   parameter int BASE_SPEED  = 300,
   parameter int SPEED_MAX   = 511,
   parameter int LOST_FRAMES = 3
) (
   input logic          clk,
   input logic          reset,
   pid_steering_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CAPTURE, MULT, SUM, OUTPUT} state_t;
   state_t r_state, w_state_nxt;
   logic r_er_q, r_eol_q, w_er_rise, w_eol_rise, w_lost_hit;
   logic signed [31:0] r_e, r_d, r_e_prev, r_integ, r_p, r_i, r_dd;
   logic signed [31:0] w_e, w_isum, w_integ, w_sum, w_sat, w_lraw, w_rraw;
   logic [9:0] w_left, w_right, r_left, r_right;
   logic signed [15:0] r_steer;
   logic [7:0] r_lost;
   logic r_valid, r_line_lost;
   assign w_er_rise  = bus.error_ready & ~r_er_q;
   assign w_eol_rise = bus.end_of_line & ~r_eol_q;
   assign w_lost_hit = (r_state == IDLE) && w_eol_rise && (r_lost == 8'(LOST_FRAMES - 1));
   assign w_e     = (bus.error > ERR_MAX) ? ERR_MAX : (bus.error < -ERR_MAX) ? -ERR_MAX : bus.error;
   assign w_isum  = r_integ + w_e;
   assign w_integ = (w_isum > I_MAX) ? I_MAX : (w_isum < -I_MAX) ? -I_MAX : w_isum;
   assign w_sum   = (r_p + r_i + r_dd) >>> SHIFT;
   assign w_sat   = (w_sum > OUT_MAX) ? OUT_MAX : (w_sum < -OUT_MAX) ? -OUT_MAX : w_sum;
   assign w_lraw  = BASE_SPEED - w_sat;
   assign w_rraw  = BASE_SPEED + w_sat;
   assign w_left  = (w_lraw < 0) ? '0 : (w_lraw > SPEED_MAX) ? 10'(SPEED_MAX) : w_lraw[9:0];
   assign w_right = (w_rraw < 0) ? '0 : (w_rraw > SPEED_MAX) ? 10'(SPEED_MAX) : w_rraw[9:0];
   assign bus.steer       = r_steer;
   assign bus.left_speed  = r_left;
   assign bus.right_speed = r_right;
   assign bus.valid       = r_valid;
   assign bus.line_lost   = r_line_lost;
   always_ff @(posedge clk)
      r_state <= reset ? IDLE : w_state_nxt;
   // end_of_line wins a tie with error_ready, so the sample is dropped
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = (w_er_rise && !w_eol_rise) ? CAPTURE : IDLE;
         CAPTURE: w_state_nxt = MULT;
         MULT:    w_state_nxt = SUM;
         SUM:     w_state_nxt = OUTPUT;
         default: w_state_nxt = IDLE;
      endcase
   end
   // Outputs are registered on the SUM->OUTPUT edge so valid and the new
   // values are visible together during OUTPUT, four cycles after detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_er_q      <= 1'b0;
         r_eol_q     <= 1'b0;
         r_e         <= '0;
         r_d         <= '0;
         r_e_prev    <= '0;
         r_integ     <= '0;
         r_p         <= '0;
         r_i         <= '0;
         r_dd        <= '0;
         r_steer     <= '0;
         r_left      <= '0;
         r_right     <= '0;
         r_lost      <= '0;
         r_valid     <= 1'b0;
         r_line_lost <= 1'b0;
      end else begin
         r_er_q  <= bus.error_ready;
         r_eol_q <= bus.end_of_line;
         r_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_eol_rise && r_lost < 8'(LOST_FRAMES))
                  r_lost <= r_lost + 8'd1;
               if (w_lost_hit) begin
                  r_steer     <= '0;
                  r_left      <= '0;
                  r_right     <= '0;
                  r_integ     <= '0;
                  r_e_prev    <= '0;
                  r_line_lost <= 1'b1;
                  r_valid     <= 1'b1;
               end
            end
            CAPTURE: begin
               r_e      <= w_e;
               r_integ  <= w_integ;
               r_d      <= w_e - r_e_prev;
               r_e_prev <= w_e;
            end
            MULT: begin
               r_p  <= r_e * KP;
               r_i  <= r_integ * KI;
               r_dd <= r_d * KD;
            end
            SUM: begin
               r_steer     <= w_sat[15:0];
               r_left      <= w_left;
               r_right     <= w_right;
               r_valid     <= 1'b1;
               r_lost      <= '0;
               r_line_lost <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pid_steering.sv
// tb_pid_steering: scoreboard bench for pid_steering with directed, hand-computed vectors
module tb_pid_steering;
   typedef struct {
      int cyc;
      int steer;
      int left;
      int right;
      bit lost;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   bit done = 1'b0;
   exp_t q[$];
   pid_steering_if bus ();
   pid_steering dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic chk_outs(input string tag, input int s, input int l, input int r, input int lost);
      check({tag, " steer"}, int'(bus.steer), s);
      check({tag, " left"}, int'(bus.left_speed), l);
      check({tag, " right"}, int'(bus.right_speed), r);
      check({tag, " line_lost"}, int'(bus.line_lost), lost);
      check({tag, " valid"}, int'(bus.valid), 0);
   endtask
   // monitor: pops the scoreboard whenever valid is presented
   always @(negedge clk) begin
      if (!done && bus.valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected valid: got valid=1 expected no update (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("valid cycle", cyc, e.cyc);
            check("steer", int'(bus.steer), e.steer);
            check("left_speed", int'(bus.left_speed), e.left);
            check("right_speed", int'(bus.right_speed), e.right);
            check("line_lost", int'(bus.line_lost), int'(e.lost));
         end
      end
   end
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.error_ready = 1'b0;
      bus.end_of_line = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic er(input int err, input int s, input int l, input int r);
      @(negedge clk);
      bus.error = err;
      bus.error_ready = 1'b1;
      q.push_back(exp_t'{cyc + 4, s, l, r, 1'b0});
      repeat (2) @(negedge clk);
      bus.error_ready = 1'b0;
      repeat (6) @(negedge clk);
   endtask
   task automatic eol(input bit hit);
      @(negedge clk);
      bus.end_of_line = 1'b1;
      if (hit) q.push_back(exp_t'{cyc + 1, 0, 0, 0, 1'b1});
      repeat (2) @(negedge clk);
      bus.end_of_line = 1'b0;
      repeat (3) @(negedge clk);
   endtask
   initial begin
      bus.error = 0;
      bus.error_ready = 1'b0;
      bus.end_of_line = 1'b0;
      do_reset();
      @(negedge clk);
      chk_outs("reset", 0, 0, 0, 0);
      er(20, 35, 265, 335);
      er(20, 30, 270, 330);
      do_reset();
      er(-500, -200, 500, 100);
      do_reset();
      eol(1'b0);
      eol(1'b0);
      eol(1'b1);
      er(0, 0, 300, 300);
      do_reset();
      er(20, 35, 265, 335);
      @(negedge clk);
      bus.error = 90;
      bus.error_ready = 1'b1;
      bus.end_of_line = 1'b1;
      repeat (2) @(negedge clk);
      bus.error_ready = 1'b0;
      bus.end_of_line = 1'b0;
      repeat (6) @(negedge clk);
      chk_outs("tie hold", 35, 265, 335, 0);
      eol(1'b0);
      eol(1'b1);
      do_reset();
      @(negedge clk);
      bus.error = 20;
      bus.error_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      bus.error_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk_outs("abort", 0, 0, 0, 0);
      er(20, 35, 265, 335);
      do_reset();
      @(negedge clk);
      bus.error = 20;
      bus.error_ready = 1'b1;
      q.push_back(exp_t'{cyc + 4, 35, 265, 335, 1'b0});
      @(negedge clk);
      bus.error_ready = 1'b0;
      @(negedge clk);
      bus.error = 50;
      bus.error_ready = 1'b1;
      repeat (8) @(negedge clk);
      bus.error_ready = 1'b0;
      repeat (6) @(negedge clk);
      chk_outs("busy ignore", 35, 265, 335, 0);
      done = 1'b1;
      check("pending updates", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pid_steering.md
PID_STEERING -- requirements
Module: pid_steering

Interface
REQ-001 Parameter KP, 4, proportional gain (unsigned integer, 0..255).
REQ-002 Parameter KI, 1, integral gain (unsigned integer, 0..255).
REQ-003 Parameter KD, 2, derivative gain (unsigned integer, 0..255).
REQ-004 Parameter SHIFT, 2, arithmetic right shift applied to the weighted sum.
REQ-005 Parameter ERR_MAX, 160, symmetric clamp on the input error.
REQ-006 Parameter I_MAX, 1000, symmetric clamp on the integral accumulator.
REQ-007 Parameter OUT_MAX, 200, symmetric saturation on steer.
REQ-008 Parameter BASE_SPEED, 300, nominal wheel speed.
REQ-009 Parameter SPEED_MAX, 511, upper clamp on wheel speeds.
REQ-010 Parameter LOST_FRAMES, 3, consecutive lost-line frames before stopping.
REQ-011 clk  in  1  single system clock; all logic on posedge.
REQ-012 reset  in  1  synchronous, active-high reset.
REQ-013 error  in  32 signed  centre-line error from the mid-line error stage (positive = path left of image centre).
REQ-014 error_ready  in  1  level, high once per frame after the measurement window; only its rising edge is a sample.
REQ-015 end_of_line  in  1  level, high when no path pixels were found in the frame; only its rising edge counts.
REQ-016 steer  out  16 signed  saturated PID output.
REQ-017 left_speed  out  10  left wheel command.
REQ-018 right_speed  out  10  right wheel command.
REQ-019 valid  out  1  one-cycle pulse when steer/speeds update.
REQ-020 line_lost  out  1  high while the lost-line stop is active.

Function
REQ-021 The block SHALL register error_ready and end_of_line and detect rising edges (in high, previous low).
REQ-022 FSM states SHALL be IDLE, CAPTURE, MULT, SUM, OUTPUT; only IDLE accepts events.
REQ-023 IDLE->CAPTURE on an error_ready rising edge; CAPTURE latches e = error clamped to [-ERR_MAX, ERR_MAX].
REQ-024 CAPTURE SHALL set integ = clamp(integ + e, -I_MAX, I_MAX) and d = e - e_prev, then set e_prev = e.
REQ-025 MULT SHALL register p = KP*e, i = KI*integ, dd = KD*d as 32-bit signed products.
REQ-026 SUM SHALL form s = (p + i + dd) >>> SHIFT (arithmetic, toward minus infinity), then saturate to [-OUT_MAX, OUT_MAX].
REQ-027 OUTPUT SHALL drive steer = s, left_speed = clamp(BASE_SPEED - s, 0, SPEED_MAX), right_speed = clamp(BASE_SPEED + s, 0, SPEED_MAX), pulse valid, clear the lost counter, deassert line_lost, return to IDLE.
REQ-028 Latency: valid high exactly 4 cycles after the cycle the rising edge is detected; outputs hold between updates.
REQ-029 In IDLE, an end_of_line rising edge SHALL increment the lost counter (saturating at LOST_FRAMES) without entering CAPTURE.
REQ-030 When the lost counter reaches LOST_FRAMES: steer = 0, both speeds = 0, integ = 0, e_prev = 0, line_lost = 1, valid pulses once on that cycle.
REQ-031 Simultaneous error_ready and end_of_line rising edges: end_of_line wins; the error sample is discarded.
REQ-032 Edges arriving outside IDLE SHALL be ignored (not queued).
REQ-033 Intermediate sums SHALL be computed at 32-bit signed width with no overflow for the legal parameter range.

Reset
REQ-034 reset SHALL force steer = 0, left_speed = 0, right_speed = 0, valid = 0, line_lost = 0, integ = 0, e_prev = 0, lost counter = 0, edge registers = 0, state = IDLE.
REQ-035 reset asserted mid-computation SHALL abort it with no valid pulse; a subsequent sample SHALL start from zero history.

Verification
REQ-036 After reset, error = 20 with an error_ready rise -> 4 cycles later valid = 1, steer = 35, left = 265, right = 335.
REQ-037 A second error = 20 sample -> integ = 40, d = 0, steer = 30, left = 270, right = 330.
REQ-038 After reset, error = -500 -> clamped to -160, raw sum -1120>>>2 = -280, steer = -200, left = 500, right = 100.
REQ-039 Three end_of_line rises with no error sample -> on the third, line_lost = 1, speeds = 0, steer = 0, one valid pulse; a following error = 0 sample -> line_lost = 0, left = right = 300.
REQ-040 error_ready and end_of_line rising in the same cycle -> no PID update, lost counter +1, outputs unchanged unless LOST_FRAMES is reached.
REQ-041 Reset asserted during MULT -> no valid pulse, all outputs 0; the next error = 20 sample reproduces REQ-036 values.
